// File: rtl/disp_arbiter_if.sv
// -----------------------------------------------------------------------------
// disp_arbiter_if
// Bundle between the display arbiter and its surroundings.
//   Requests   : req_err / req_evt level-sampled request strobes
//   Payloads   : err_disp/err_led, evt_disp/evt_led message contents,
//                base_disp/base_led/blink_mask live default view
//   Display    : disp3..disp0 segment patterns, led LED drive
//   Status     : busy, err_done, evt_done, evt_dropped
// Modports: slave = the arbiter, master = requesters / display consumer.
// -----------------------------------------------------------------------------
interface disp_arbiter_if;
   logic        req_err;
   logic [31:0] err_disp;
   logic [7:0]  err_led;
   logic        req_evt;
   logic [31:0] evt_disp;
   logic [7:0]  evt_led;
   logic [31:0] base_disp;
   logic [7:0]  base_led;
   logic [7:0]  blink_mask;
   logic [7:0]  disp3;
   logic [7:0]  disp2;
   logic [7:0]  disp1;
   logic [7:0]  disp0;
   logic [7:0]  led;
   logic        busy;
   logic        err_done;
   logic        evt_done;
   logic        evt_dropped;

   modport slave (
      input  req_err, err_disp, err_led,
      input  req_evt, evt_disp, evt_led,
      input  base_disp, base_led, blink_mask,
      output disp3, disp2, disp1, disp0, led,
      output busy, err_done, evt_done, evt_dropped
   );

   modport master (
      output req_err, err_disp, err_led,
      output req_evt, evt_disp, evt_led,
      output base_disp, base_led, blink_mask,
      input  disp3, disp2, disp1, disp0, led,
      input  busy, err_done, evt_done, evt_dropped
   );
endinterface

// File: rtl/disp_arbiter.sv
// -----------------------------------------------------------------------------
// disp_arbiter
// Chooses what the 4-digit / 8-LED display shows: the live base view (with
// optional LED blinking), a timed error message, or a timed event message.
// Errors preempt events; a preempted or overlapping event is parked as
// pending and shown with a fresh full hold once the error has finished.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - disp_arbiter_if.slave (requests, payloads, display outputs, status)
// Parameters:
//   HOLD_CYC  - cycles each message stays on the display (1..65535)
//   BLINK_DIV - cycles per blink half-period (1..65535)
// -----------------------------------------------------------------------------
module disp_arbiter #(
   parameter int unsigned HOLD_CYC  = 100,
   parameter int unsigned BLINK_DIV = 25
) (
   input  logic           clk,
   input  logic           rst,
   disp_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      BASE     = 2'd0,
      SHOW_ERR = 2'd1,
      SHOW_EVT = 2'd2
   } state_t;

   localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
   localparam logic [15:0] BLINK_LAST = 16'(BLINK_DIV - 1);

   state_t      state, state_nx;
   logic [15:0] timer, timer_nx;
   logic        pend_evt, pend_nx;
   logic        lat_err, lat_evt;
   logic        err_done_nx, evt_done_nx, evt_dropped_nx;
   logic        err_done_q, evt_done_q, evt_dropped_q;
   logic        expired;

   logic [31:0] err_disp_q, evt_disp_q;
   logic [7:0]  err_led_q, evt_led_q;

   logic [15:0] blink_cnt;
   logic        blink_phase;

   logic [31:0] disp_word;
   logic [7:0]  led_word;

   // Timer holds the number of edges already spent in the current message,
   // so the last cycle of a hold is the one where it reads HOLD_CYC-1.
   assign expired = (timer == HOLD_LAST);

   // State, timer, pending flag and status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= BASE;
         timer         <= 16'd0;
         pend_evt      <= 1'b0;
         err_done_q    <= 1'b0;
         evt_done_q    <= 1'b0;
         evt_dropped_q <= 1'b0;
      end else begin
         state         <= state_nx;
         timer         <= timer_nx;
         pend_evt      <= pend_nx;
         err_done_q    <= err_done_nx;
         evt_done_q    <= evt_done_nx;
         evt_dropped_q <= evt_dropped_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      timer_nx       = timer + 16'd1;
      pend_nx        = pend_evt;
      lat_err        = 1'b0;
      lat_evt        = 1'b0;
      err_done_nx    = 1'b0;
      evt_done_nx    = 1'b0;
      evt_dropped_nx = 1'b0;

      case (state)
         BASE: begin
            timer_nx = 16'd0;
            if (bus.req_err) begin
               state_nx = SHOW_ERR;
               lat_err  = 1'b1;
               if (bus.req_evt) begin
                  lat_evt = 1'b1;
                  pend_nx = 1'b1;
               end
            end else if (bus.req_evt) begin
               state_nx = SHOW_EVT;
               lat_evt  = 1'b1;
            end
         end

         SHOW_ERR: begin
            // A new event during an error always wins the single pending slot;
            // an older pending event is discarded and reported.
            if (bus.req_evt) begin
               lat_evt        = 1'b1;
               pend_nx        = 1'b1;
               evt_dropped_nx = pend_evt;
            end
            if (bus.req_err) begin
               lat_err  = 1'b1;
               timer_nx = 16'd0;
            end else if (expired) begin
               err_done_nx = 1'b1;
               timer_nx    = 16'd0;
               if (pend_nx) begin
                  state_nx = SHOW_EVT;
                  pend_nx  = 1'b0;
               end else begin
                  state_nx = BASE;
               end
            end
         end

         SHOW_EVT: begin
            if (expired) begin
               // Event completed its hold; requests on this edge start afresh
               // exactly as they would from the base view.
               evt_done_nx = 1'b1;
               timer_nx    = 16'd0;
               state_nx    = BASE;
               if (bus.req_err) begin
                  state_nx = SHOW_ERR;
                  lat_err  = 1'b1;
                  if (bus.req_evt) begin
                     lat_evt = 1'b1;
                     pend_nx = 1'b1;
                  end
               end else if (bus.req_evt) begin
                  state_nx = SHOW_EVT;
                  lat_evt  = 1'b1;
               end
            end else if (bus.req_err) begin
               // Preemption: the event latch keeps the interrupted message
               // (or the new one if it arrives on the same edge).
               state_nx = SHOW_ERR;
               timer_nx = 16'd0;
               lat_err  = 1'b1;
               pend_nx  = 1'b1;
               lat_evt  = bus.req_evt;
            end else if (bus.req_evt) begin
               lat_evt  = 1'b1;
               timer_nx = 16'd0;
            end
         end

         default: begin
            state_nx = BASE;
            timer_nx = 16'd0;
            pend_nx  = 1'b0;
         end
      endcase
   end

   // Payload latches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_disp_q <= 32'd0;
         err_led_q  <= 8'd0;
         evt_disp_q <= 32'd0;
         evt_led_q  <= 8'd0;
      end else begin
         if (lat_err) begin
            err_disp_q <= bus.err_disp;
            err_led_q  <= bus.err_led;
         end
         if (lat_evt) begin
            evt_disp_q <= bus.evt_disp;
            evt_led_q  <= bus.evt_led;
         end
      end
   end

   // Free-running blink divider; phase starts high so masked LEDs are lit
   // for the first half-period after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt   <= 16'd0;
         blink_phase <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= 16'd0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 16'd1;
      end
   end

   // Display mux: base view follows its inputs with no register in the path.
   always_comb begin
      disp_word = bus.base_disp;
      led_word  = bus.base_led & ~(blink_phase ? 8'h00 : bus.blink_mask);
      case (state)
         SHOW_ERR: begin
            disp_word = err_disp_q;
            led_word  = err_led_q;
         end
         SHOW_EVT: begin
            disp_word = evt_disp_q;
            led_word  = evt_led_q;
         end
         default: begin
            disp_word = bus.base_disp;
            led_word  = bus.base_led & ~(blink_phase ? 8'h00 : bus.blink_mask);
         end
      endcase
   end

   assign bus.disp3       = disp_word[31:24];
   assign bus.disp2       = disp_word[23:16];
   assign bus.disp1       = disp_word[15:8];
   assign bus.disp0       = disp_word[7:0];
   assign bus.led         = led_word;
   assign bus.busy        = (state != BASE);
   assign bus.err_done    = err_done_q;
   assign bus.evt_done    = evt_done_q;
   assign bus.evt_dropped = evt_dropped_q;

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 100, message display duration in clk cycles (1..65535).
REQ-002 SHALL have parameter BLINK_DIV, default 25, clk cycles per blink half-period (1..65535).
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_err  in  1  error-message request, sampled per edge, highest priority.
REQ-006 err_disp  in  32  error digits {disp3,disp2,disp1,disp0}; err_led  in  8  error LED pattern.
REQ-007 req_evt  in  1  event-message request (e.g. sink or score), sampled per edge.
REQ-008 evt_disp  in  32  event digits; evt_led  in  8  event LED pattern.
REQ-009 base_disp  in  32  live default digits; base_led  in  8  live default LEDs; blink_mask  in  8  base LEDs subject to blink.
REQ-010 disp3..disp0  out  8 each  segment patterns; led  out  8  LED drive.
REQ-011 busy  out  1  high when not in BASE.
REQ-012 err_done, evt_done  out  1 each  one-cycle pulse when the message completes its full hold.
REQ-013 evt_dropped  out  1  one-cycle pulse when a pending event is overwritten.

Function
REQ-014 SHALL implement states BASE, SHOW_ERR, SHOW_EVT; busy = (state != BASE).
REQ-015 Payload latching: on grant, the SHALL latch the requester's disp/led payloads at that edge; later payload changes are ignored until the next grant.
REQ-016 Output mapping: the block SHALL drive disp3 = payload[31:24] through disp0 = payload[7:0]. Outputs SHALL be combinational from registered state/latches.
REQ-017 BASE: disp = base_disp. The block SHALL drive led = base_led with blink_mask bits forced 0 while blink_phase = 0 (zero latency from base inputs).
REQ-018 SHOW_ERR/SHOW_EVT: outputs SHALL show the latched payload unmodified, with no blink.
REQ-019 BASE, req_err=1: the block SHALL enter SHOW_ERR and clear the timer. If req_evt=1 on the same edge, it SHALL also latch the event payload and set pend_evt.
REQ-020 BASE, req_evt=1 only: the block SHALL enter SHOW_EVT and clear the timer.
REQ-021 Hold timer: 16-bit. Each SHOW state SHALL last exactly HOLD_CYC cycles, entered at edge N and exited at edge N+HOLD_CYC.
REQ-022 SHOW_EVT + req_err: the block SHALL preempt to SHOW_ERR, clear the timer and set pend_evt. The event latch SHALL be retained. evt_done SHALL NOT pulse.
REQ-023 SHOW_EVT + req_evt (no req_err): the block SHALL relatch the event payload and clear the timer (retrigger).
REQ-024 SHOW_ERR + req_err: the block SHALL relatch the error payload and clear the timer (retrigger).
REQ-025 SHOW_ERR + req_evt: the block SHALL relatch the event payload and set pend_evt. If pend_evt was already 1, it SHALL pulse evt_dropped.
REQ-026 SHOW_ERR expiry: the block SHALL pulse err_done. If pend_evt=1, it SHALL go to SHOW_EVT with timer 0 and clear pend_evt (a preempted event gets a fresh full hold); otherwise it SHALL go to BASE.
REQ-027 SHOW_EVT expiry: the block SHALL pulse evt_done and go to BASE, unless req_err or req_evt is present on the expiry edge, in which case REQ-019/020 apply on that edge.
REQ-028 Done/dropped pulses SHALL be registered, high for exactly the one cycle following the causing edge.
REQ-029 Blink: a free-running counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap, independent of state.
REQ-030 Requests are level-sampled: a request held high SHALL retrigger every cycle; requesters SHALL pulse.

Reset
REQ-031 On rst, the block SHALL reset to: state BASE, timer 0, blink counter 0, blink_phase 1, pend_evt 0, latches 0, busy/err_done/evt_done/evt_dropped 0. Outputs then follow base_disp/base_led.
REQ-032 rst mid-message SHALL abort it immediately without a done pulse; the pending event SHALL be lost.

Verification (HOLD_CYC=4, BLINK_DIV=2)
REQ-033 BASE, base_led=8'hFF, blink_mask=8'h0F: led SHALL alternate 8'hFF/8'hF0 every 2 cycles, starting 8'hFF after reset.
REQ-034 req_evt pulse with evt_disp=32'h3F06_5B4F: disp3..0 SHALL be 3F,06,5B,4F for exactly 4 cycles, then evt_done SHALL pulse once and the outputs SHALL return to base.
REQ-035 req_evt, then req_err 2 cycles later: error SHALL show for 4 cycles with err_done, then the event SHALL show a full 4 cycles with evt_done, then BASE; total busy 10 cycles.
REQ-036 Simultaneous req_err+req_evt in BASE: error first, then event; no evt_dropped.
REQ-037 During SHOW_ERR with pend_evt=1, a new req_evt SHALL cause an evt_dropped pulse, and the event shown afterward SHALL be the newer payload.
REQ-038 rst asserted in SHOW_ERR cycle 2: the block SHALL go busy=0 immediately, with no err_done, and no event follows.
